// File: rtl/cpu_sequencer_if.sv
// Control interface between the microcode sequencer and the CPU datapath.
// The sequencer is the master: it reads the IR opcode and ALU flags and drives the control word.
interface cpu_sequencer_if;
    logic [3:0]  opcode;
    logic        cf;
    logic        zf;
    logic [14:0] control_signals;
    logic [2:0]  tstate;
    logic        halted;

    modport master (
        input  opcode,
        input  cf,
        input  zf,
        output control_signals,
        output tstate,
        output halted
    );

    modport slave (
        output opcode,
        output cf,
        output zf,
        input  control_signals,
        input  tstate,
        input  halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU: steps T0..T4 and decodes opcode and flags
// into the 15-bit control word {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}.
module cpu_sequencer (
    input  logic             clk,
    input  logic             rst_n,
    cpu_sequencer_if.master  bus
);

    localparam int CP   = 14;
    localparam int EP   = 13;
    localparam int LP   = 12;
    localparam int NLMA = 11;
    localparam int NLMD = 10;
    localparam int NCE  = 9;
    localparam int NLR  = 8;
    localparam int NLI  = 7;
    localparam int NEI  = 6;
    localparam int NLA  = 5;
    localparam int EA   = 4;
    localparam int SUB  = 3;
    localparam int EU   = 2;
    localparam int NLB  = 1;
    localparam int NLO  = 0;

    localparam logic [14:0] IDLE_WORD = 15'h0FE3;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    tstate_t     state;
    logic        halted_q;
    logic [14:0] word;

    // Final T-state of each instruction; everything not using memory or the ALU ends in T2.
    function automatic tstate_t last_state(input logic [3:0] op);
        case (op)
            OP_LDA:                 last_state = T3;
            OP_ADD, OP_SUB, OP_STA: last_state = T4;
            default:                last_state = T2;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= T0;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            state <= T0;
        end else begin
            case (state)
                T0: state <= T1;
                T1: state <= T2;
                T2: begin
                    if (bus.opcode == OP_HLT) begin
                        halted_q <= 1'b1;
                        state    <= T0;
                    end else if (last_state(bus.opcode) == T2) begin
                        state <= T0;
                    end else begin
                        state <= T3;
                    end
                end
                T3:      state <= (last_state(bus.opcode) == T3) ? T0 : T4;
                T4:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Gating on rst_n makes the word go idle the instant reset asserts, not at the next edge.
    always_comb begin
        word = IDLE_WORD;
        if (rst_n && !halted_q) begin
            case (state)
                T0: begin
                    word[EP]   = 1'b1;
                    word[NLMA] = 1'b0;
                end
                T1: begin
                    word[NCE] = 1'b0;
                    word[NLI] = 1'b0;
                    word[CP]  = 1'b1;
                end
                T2: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            word[NEI]  = 1'b0;
                            word[NLMA] = 1'b0;
                        end
                        OP_LDI: begin
                            word[NEI] = 1'b0;
                            word[NLA] = 1'b0;
                        end
                        OP_JMP: begin
                            word[NEI] = 1'b0;
                            word[LP]  = 1'b1;
                        end
                        OP_JC: begin
                            if (bus.cf) begin
                                word[NEI] = 1'b0;
                                word[LP]  = 1'b1;
                            end
                        end
                        OP_JZ: begin
                            if (bus.zf) begin
                                word[NEI] = 1'b0;
                                word[LP]  = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            word[EA]  = 1'b1;
                            word[NLO] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            word[NCE] = 1'b0;
                            word[NLA] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            word[NCE] = 1'b0;
                            word[NLB] = 1'b0;
                            word[SUB] = (bus.opcode == OP_SUB);
                        end
                        OP_STA: begin
                            word[EA]   = 1'b1;
                            word[NLMD] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (bus.opcode)
                        OP_ADD, OP_SUB: begin
                            word[EU]  = 1'b1;
                            word[NLA] = 1'b0;
                            word[SUB] = (bus.opcode == OP_SUB);
                        end
                        OP_STA: word[NLR] = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.control_signals = word;
    assign bus.tstate          = state;
    assign bus.halted          = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-scenario tasks compare each cycle against a table-driven model
// that lists which control signals an instruction asserts in each of its cycles.
module tb_cpu_sequencer;

  // Asserted-signal masks: a control word is IDLE with these bits flipped to their active level.
  localparam logic [14:0] IDLE  = 15'h0FE3;
  localparam logic [14:0] S_CP  = 15'h4000;
  localparam logic [14:0] S_EP  = 15'h2000;
  localparam logic [14:0] S_LP  = 15'h1000;
  localparam logic [14:0] S_LMA = 15'h0800;
  localparam logic [14:0] S_LMD = 15'h0400;
  localparam logic [14:0] S_CE  = 15'h0200;
  localparam logic [14:0] S_LR  = 15'h0100;
  localparam logic [14:0] S_LI  = 15'h0080;
  localparam logic [14:0] S_EI  = 15'h0040;
  localparam logic [14:0] S_LA  = 15'h0020;
  localparam logic [14:0] S_EA  = 15'h0010;
  localparam logic [14:0] S_SUB = 15'h0008;
  localparam logic [14:0] S_EU  = 15'h0004;
  localparam logic [14:0] S_LB  = 15'h0002;
  localparam logic [14:0] S_LO  = 15'h0001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [14:0] exp_q[$];
  logic watch_nlr = 1'b0;
  logic nlr_seen  = 1'b0;

  // Reference program: fetch cycles, then execute cycles, one asserted-signal mask per cycle.
  function automatic void build_expected(input logic [3:0] op, input logic c, input logic z);
    exp_q = {};
    exp_q.push_back(S_EP | S_LMA);
    exp_q.push_back(S_CP | S_CE | S_LI);
    case (op)
      4'h0: begin exp_q.push_back(S_EI | S_LMA); exp_q.push_back(S_CE | S_LA); end
      4'h1: begin
        exp_q.push_back(S_EI | S_LMA); exp_q.push_back(S_CE | S_LB); exp_q.push_back(S_EU | S_LA);
      end
      4'h2: begin
        exp_q.push_back(S_EI | S_LMA);
        exp_q.push_back(S_CE | S_LB | S_SUB);
        exp_q.push_back(S_EU | S_LA | S_SUB);
      end
      4'h3: begin
        exp_q.push_back(S_EI | S_LMA); exp_q.push_back(S_EA | S_LMD); exp_q.push_back(S_LR);
      end
      4'h4: exp_q.push_back(S_EI | S_LA);
      4'h5: exp_q.push_back(S_EI | S_LP);
      4'h6: exp_q.push_back(c ? (S_EI | S_LP) : 15'h0);
      4'h7: exp_q.push_back(z ? (S_EI | S_LP) : 15'h0);
      4'hE: exp_q.push_back(S_EA | S_LO);
      default: exp_q.push_back(15'h0);
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic c, input logic z);
    @(negedge clk);
    bus.opcode = op;
    bus.cf     = c;
    bus.zf     = z;
    #1;
  endtask

  always @* if (watch_nlr && !bus.control_signals[8]) nlr_seen = 1'b1;

  // Single-bus-driver rule: Ep, nCE=0, nEi=0, Ea, Eu.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      tests_run++;
      assert ((int'(bus.control_signals[13]) + int'(!bus.control_signals[9]) +
               int'(!bus.control_signals[6]) + int'(bus.control_signals[4]) +
               int'(bus.control_signals[2])) <= 1)
      else begin
        tests_failed++;
        $display("FAIL bus_contention: control=%h tstate=%0d", bus.control_signals, bus.tstate);
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    bus.opcode = 4'h4; bus.cf = 1'b0; bus.zf = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      tests_run++;
      if (bus.control_signals !== IDLE || bus.tstate !== 3'd0 || bus.halted !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state: control=%h tstate=%0d halted=%b, want %h 0 0",
                 bus.control_signals, bus.tstate, bus.halted, IDLE);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_ldi;
    build_expected(4'h4, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      drive(4'h4, 1'b0, 1'b0);
      tests_run++;
      if (bus.control_signals !== (IDLE ^ exp_q[i]) || bus.tstate !== 3'(i)) begin
        tests_failed++;
        $display("FAIL ldi_cycle%0d: control=%h tstate=%0d, want %h %0d",
                 i, bus.control_signals, bus.tstate, IDLE ^ exp_q[i], i);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.tstate !== 3'd0) begin
      tests_failed++;
      $display("FAIL ldi_length: tstate=%0d after 3 cycles, want 0", bus.tstate);
    end
  endtask

  task automatic test_sub;
    logic c, z;
    c = 1'($urandom); z = 1'($urandom);
    build_expected(4'h2, c, z);
    foreach (exp_q[i]) begin
      drive(4'h2, c, z);
      tests_run++;
      if (bus.control_signals !== (IDLE ^ exp_q[i]) || bus.tstate !== 3'(i)) begin
        tests_failed++;
        $display("FAIL sub_cycle%0d: control=%h tstate=%0d, want %h %0d",
                 i, bus.control_signals, bus.tstate, IDLE ^ exp_q[i], i);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.tstate !== 3'd0) begin
      tests_failed++;
      $display("FAIL sub_length: tstate=%0d after 5 cycles, want 0", bus.tstate);
    end
  endtask

  task automatic test_cond_jump;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] op;
      logic flag, c, z;
      op   = (k < 2) ? 4'h6 : 4'h7;
      flag = 1'(k % 2);
      c    = (op == 4'h6) ? flag : 1'($urandom);
      z    = (op == 4'h7) ? flag : 1'($urandom);
      build_expected(op, c, z);
      foreach (exp_q[i]) begin
        drive(op, c, z);
        tests_run++;
        if (bus.control_signals !== (IDLE ^ exp_q[i]) || bus.tstate !== 3'(i)) begin
          tests_failed++;
          $display("FAIL jump_op%h_flag%0d_cycle%0d: control=%h tstate=%0d, want %h %0d",
                   op, flag, i, bus.control_signals, bus.tstate, IDLE ^ exp_q[i], i);
        end
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      logic c, z;
      op = 4'($urandom_range(0, 14));
      c  = 1'($urandom);
      z  = 1'($urandom);
      build_expected(op, c, z);
      foreach (exp_q[i]) begin
        drive(op, c, z);
        tests_run++;
        if (bus.control_signals !== (IDLE ^ exp_q[i]) || bus.tstate !== 3'(i) ||
            bus.halted !== 1'b0) begin
          tests_failed++;
          $display("FAIL random_op%h_cycle%0d: control=%h tstate=%0d halted=%b, want %h %0d 0",
                   op, i, bus.control_signals, bus.tstate, bus.halted, IDLE ^ exp_q[i], i);
        end
      end
    end
  endtask

  task automatic test_sta_async_reset;
    build_expected(4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(4'h3, 1'b0, 1'b0);
      tests_run++;
      if (bus.control_signals !== (IDLE ^ exp_q[i]) || bus.tstate !== 3'(i)) begin
        tests_failed++;
        $display("FAIL sta_cycle%0d: control=%h tstate=%0d, want %h %0d",
                 i, bus.control_signals, bus.tstate, IDLE ^ exp_q[i], i);
      end
    end
    nlr_seen  = 1'b0;
    watch_nlr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.control_signals !== IDLE || bus.tstate !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_reset_immediate: control=%h tstate=%0d, want %h 0",
               bus.control_signals, bus.tstate, IDLE);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.control_signals !== IDLE || bus.tstate !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_reset_hold: control=%h tstate=%0d, want %h 0",
               bus.control_signals, bus.tstate, IDLE);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    watch_nlr = 1'b0;
    tests_run++;
    if (nlr_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_nlr: nLr asserted=%b, want 0", nlr_seen);
    end
    build_expected(4'h0, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      drive(4'h0, 1'b0, 1'b0);
      tests_run++;
      if (bus.control_signals !== (IDLE ^ exp_q[i]) || bus.tstate !== 3'(i)) begin
        tests_failed++;
        $display("FAIL post_reset_lda_cycle%0d: control=%h tstate=%0d, want %h %0d",
                 i, bus.control_signals, bus.tstate, IDLE ^ exp_q[i], i);
      end
    end
  endtask

  task automatic test_halt;
    build_expected(4'hF, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      drive(4'hF, 1'b0, 1'b0);
      tests_run++;
      if (bus.control_signals !== (IDLE ^ exp_q[i]) || bus.tstate !== 3'(i) ||
          bus.halted !== 1'b0) begin
        tests_failed++;
        $display("FAIL hlt_cycle%0d: control=%h tstate=%0d halted=%b, want %h %0d 0",
                 i, bus.control_signals, bus.tstate, bus.halted, IDLE ^ exp_q[i], i);
      end
    end
    for (int n = 0; n < 20; n++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      tests_run++;
      if (bus.control_signals !== IDLE || bus.tstate !== 3'd0 || bus.halted !== 1'b1) begin
        tests_failed++;
        $display("FAIL halted_cycle%0d: control=%h tstate=%0d halted=%b, want %h 0 1",
                 n, bus.control_signals, bus.tstate, bus.halted, IDLE);
      end
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.halted !== 1'b0 || bus.control_signals !== IDLE) begin
      tests_failed++;
      $display("FAIL halt_reset_clear: halted=%b control=%h, want 0 %h",
               bus.halted, bus.control_signals, IDLE);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    drive(4'h4, 1'b0, 1'b0);
    tests_run++;
    if (bus.control_signals !== (IDLE ^ (S_EP | S_LMA)) || bus.tstate !== 3'd0 ||
        bus.halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_restart: control=%h tstate=%0d halted=%b, want %h 0 0",
               bus.control_signals, bus.tstate, bus.halted, IDLE ^ (S_EP | S_LMA));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ldi();
    test_sub();
    test_cond_jump();
    test_random();
    test_sta_async_reset();
    test_halt();
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
